// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// MUL_UNSIGNED_EN adds one extra iteration for unsigned operands.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        PM   = 3'd1,
        P2M  = 3'd2,
        NM   = 3'd3,
        N2M  = 3'd4
    } booth_digit_e;

    // Unsigned operands need one more digit to absorb the multiplier's top bit.
    function automatic int iter_count(input int width, input logic unsigned_mode);
        return (width / 2) + (unsigned_mode ? 1 : 0);
    endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// Handshake and operand/result bundle between the control unit and the multiplier.
// MUL_UNSIGNED_EN adds the signed_op select.
interface booth_mul_seq_if #(parameter int WIDTH = 32);

    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
`ifdef MUL_UNSIGNED_EN
    logic                 signed_op;
`endif
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, multiplicand, multiplier,
`ifdef MUL_UNSIGNED_EN
        output signed_op,
`endif
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
`ifdef MUL_UNSIGNED_EN
        input  signed_op,
`endif
        output busy, done, product
    );

endinterface

// File: rtl/booth_mul_seq_recoder.sv
// Combinational radix-4 Booth digit recoder and the matching addend/carry-in selector.
// The addend is returned pre-inverted for negative digits; the caller adds o_cin.
module booth_recoder
    import mul_pkg::*;
(
    input  logic [2:0]   i_win,
    output booth_digit_e o_digit
);

    always_comb begin
        o_digit = ZERO;
        case (i_win)
            3'b001, 3'b010: o_digit = PM;
            3'b011:         o_digit = P2M;
            3'b100:         o_digit = N2M;
            3'b101, 3'b110: o_digit = NM;
            default:        o_digit = ZERO;
        endcase
    end

endmodule

module booth_addend
    import mul_pkg::*;
#(
    parameter int AW = 34
) (
    input  logic [AW-1:0] i_m,
    input  booth_digit_e  i_digit,
    output logic [AW-1:0] o_addend,
    output logic          o_cin
);

    logic [AW-1:0] w_m2;

    assign w_m2 = {i_m[AW-2:0], 1'b0};

    always_comb begin
        o_addend = '0;
        o_cin    = 1'b0;
        case (i_digit)
            PM:  o_addend = i_m;
            P2M: o_addend = w_m2;
            NM:  begin o_addend = ~i_m;  o_cin = 1'b1; end
            N2M: begin o_addend = ~w_m2; o_cin = 1'b1; end
            default: begin o_addend = '0; o_cin = 1'b0; end
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Multi-cycle radix-4 Booth multiplier: one digit per clock, product to Z as {HI,LO}.
// Define MUL_UNSIGNED_EN to add the signed_op port and unsigned mode.
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          clear,
    booth_mul_seq_if.slave bus
);

    localparam int AW    = WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH / 2 + 2);

    mul_state_e          r_state;
    mul_state_e          w_state_next;
    logic [AW-1:0]       r_m;
    logic [AW-1:0]       r_acc;
    logic [WIDTH-1:0]    r_q;
    logic                r_qprev;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*WIDTH-1:0]  r_product;

    logic                w_unsigned;
    logic                w_extra;
    logic                w_last;
    logic                w_accept;
    logic [2:0]          w_win;
    booth_digit_e        w_digit;
    logic [AW-1:0]       w_addend;
    logic                w_cin;
    logic [AW-1:0]       w_sum;
    logic [AW-1:0]       w_m_ext;

`ifdef MUL_UNSIGNED_EN
    logic                r_signed;

    assign w_unsigned = ~r_signed;
    assign w_m_ext    = bus.signed_op ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                      : {2'b00, bus.multiplicand};
`else
    assign w_unsigned = 1'b0;
    assign w_m_ext    = {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
`endif

    // The unsigned extra digit sits above all multiplier bits, so its window
    // ignores Q (which by then holds product bits) and the result is taken unshifted.
    assign w_extra  = w_unsigned && (r_cnt == CNT_W'(WIDTH / 2));
    assign w_last   = (r_cnt == CNT_W'(iter_count(WIDTH, w_unsigned) - 1));
    assign w_win    = w_extra ? {2'b00, r_qprev} : {r_q[1:0], r_qprev};
    assign w_sum    = r_acc + w_addend + AW'(w_cin);
    assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));

    booth_recoder u_recoder (
        .i_win   (w_win),
        .o_digit (w_digit)
    );

    booth_addend #(.AW(AW)) u_addend (
        .i_m      (r_m),
        .i_digit  (w_digit),
        .o_addend (w_addend),
        .o_cin    (w_cin)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    w_state_next = bus.start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_m       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_qprev   <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
`ifdef MUL_UNSIGNED_EN
            r_signed  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_m     <= w_m_ext;
            r_q     <= bus.multiplier;
            r_acc   <= '0;
            r_qprev <= 1'b0;
            r_cnt   <= '0;
`ifdef MUL_UNSIGNED_EN
            r_signed <= bus.signed_op;
`endif
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_extra) begin
                r_product <= {w_sum[WIDTH-1:0], r_q};
            end else begin
                r_acc   <= {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
                r_q     <= {w_sum[1:0], r_q[WIDTH-1:2]};
                r_qprev <= r_q[1];
                // Low 2*WIDTH bits of the shifted {acc,Q}.
                if (w_last) r_product <= {w_sum, r_q[WIDTH-1:2]};
            end
        end
    end

    assign bus.busy    = (r_state == RUN);
    assign bus.done    = (r_state == DONE);
    assign bus.product = r_product;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed cases plus random operands
// against a plain-arithmetic product model (MUL_UNSIGNED_EN adds unsigned cases).
module tb_booth_mul_seq;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic clear = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    booth_mul_seq_if #(.WIDTH(W)) bus();

    booth_mul_seq #(.WIDTH(W)) dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q, input bit sgn);
        longint a;
        longint b;
        logic [63:0] u;
        if (sgn) begin
            a = longint'($signed(m));
            b = longint'($signed(q));
            return 64'(a * b);
        end
        u = {32'd0, m} * {32'd0, q};
        return u;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves start low at the negedge after the accept edge.
    task automatic start_op(input logic [31:0] m, input logic [31:0] q, input bit sgn);
        bus.start        = 1'b1;
        bus.multiplicand = m;
        bus.multiplier   = q;
`ifdef MUL_UNSIGNED_EN
        bus.signed_op    = sgn;
`endif
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && n < 40) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q, input bit sgn);
        int n;
        bit bok;
        start_op(m, q, sgn);
        wait_done(n, bok);
        chk({tag, "_lat"}, 64'(n), sgn ? 64'd16 : 64'd17);
        chk({tag, "_busy"}, 64'(bok), 64'd1);
        chk({tag, "_prod"}, bus.product, ref_mul(m, q, sgn));
        chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int n;
        bit bok;
        logic [31:0] rm;
        logic [31:0] rq;

        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
`ifdef MUL_UNSIGNED_EN
        bus.signed_op    = 1'b1;
`endif

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_prod", bus.product, 64'd0);
        clear = 1'b1;
        @(negedge clk);

        run_op("m5x10", 32'h0000_0005, 32'h0000_0010, 1'b1);
        chk("m5x10_const", bus.product, 64'h0000_0000_0000_0050);

        start_op(32'hFFFF_FFFF, 32'h0000_0005, 1'b1);
        wait_done(n, bok);
        chk("neg1x5_lat", 64'(n), 64'd16);
        chk("neg1x5_prod", bus.product, 64'hFFFF_FFFF_FFFF_FFFB);
        start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        chk("b2b_done_drop", 64'(bus.done), 64'd0);
        chk("b2b_busy_rise", 64'(bus.busy), 64'd1);
        chk("b2b_prod_held", bus.product, 64'hFFFF_FFFF_FFFF_FFFB);
        wait_done(n, bok);
        chk("b2b_lat", 64'(n), 64'd16);
        chk("b2b_busy", 64'(bok), 64'd1);
        chk("minsq_prod", bus.product, 64'h4000_0000_0000_0000);
        @(negedge clk);
        chk("b2b_done_pulse", 64'(bus.done), 64'd0);

        run_op("maxxmin", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        chk("maxxmin_const", bus.product, 64'hC000_0000_8000_0000);
        run_op("x0", 32'h1234_5678, 32'h0000_0000, 1'b1);
        chk("x0_const", bus.product, 64'd0);

        // start during RUN must be ignored
        start_op(32'h0000_0123, 32'h0000_0456, 1'b1);
        repeat (4) @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = 32'h0000_0BAD;
        bus.multiplier   = 32'h0000_0F00;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n, bok);
        chk("ign_lat", 64'(n + 5), 64'd16);
        chk("ign_prod", bus.product, 64'h0000_0000_0004_EDC2);
        @(negedge clk);
        chk("ign_idle", 64'(bus.busy), 64'd0);

        // asynchronous clear in the middle of an operation
        start_op(32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
        repeat (7) @(negedge clk);
        #2 clear = 1'b0;
        #1;
        chk("clr_busy", 64'(bus.busy), 64'd0);
        chk("clr_done", 64'(bus.done), 64'd0);
        chk("clr_prod", bus.product, 64'd0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        run_op("m3xn3", 32'h0000_0003, 32'hFFFF_FFFD, 1'b1);
        chk("m3xn3_const", bus.product, 64'hFFFF_FFFF_FFFF_FFF7);

        for (int i = 0; i < 20; i++) begin
            rm = $urandom;
            rq = $urandom;
            run_op("rnd_s", rm, rq, 1'b1);
        end

`ifdef MUL_UNSIGNED_EN
        run_op("u_ffsq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("u_ffsq_const", bus.product, 64'hFFFF_FFFE_0000_0001);
        run_op("s_ffsq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("s_ffsq_const", bus.product, 64'h0000_0000_0000_0001);
        run_op("u_min", 32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("u_min_const", bus.product, 64'h4000_0000_0000_0000);
        for (int i = 0; i < 10; i++) begin
            rm = $urandom;
            rq = $urandom;
            run_op("rnd_u", rm, rq, 1'b0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
